// File: rtl/ym_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ym_pkg : states, command codes and register masks shared by recorder/player |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package ym_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAITFRAME = 2'd1,
    ST_DUMP      = 2'd2,
    ST_FULL      = 2'd3
  } ym_state_t;

  localparam logic [7:0] CMD_START   = 8'd1;
  localparam logic [7:0] CMD_STOP    = 8'd2;
  localparam logic [7:0] R13_NOWRITE = 8'hFF;
  localparam int         NUM_REGS    = 16;

  // Bits of each YM2149 register that the chip actually implements.
  function automatic logic [7:0] reg_mask(input logic [3:0] r);
    logic [7:0] m;
    case (r)
      4'd0:    m = 8'hFF;
      4'd1:    m = 8'h0F;
      4'd2:    m = 8'hFF;
      4'd3:    m = 8'h0F;
      4'd4:    m = 8'hFF;
      4'd5:    m = 8'h0F;
      4'd6:    m = 8'h1F;
      4'd7:    m = 8'hFF;
      4'd8:    m = 8'h1F;
      4'd9:    m = 8'h1F;
      4'd10:   m = 8'h1F;
      4'd11:   m = 8'hFF;
      4'd12:   m = 8'hFF;
      4'd13:   m = 8'h0F;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ym_shadow_regs.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ym_shadow_regs : 16 x 8 shadow of snooped YM2149 writes + R13-written flag  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ym_shadow_regs
  import ym_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wr,
  input  logic [3:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [3:0] i_raddr,
  output logic [7:0] o_rdata,
  input  logic       i_r13_clr,
  output logic       o_r13_written
);

  logic [7:0] r_regs [NUM_REGS];
  logic       r_r13_written;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_r13_written <= 1'b0;
    end else begin
      if (i_wr) begin
        r_regs[i_waddr] <= i_wdata;
      end
      // A fresh R13 write outranks a simultaneous clear.
      if (i_wr && (i_waddr == 4'd13)) begin
        r_r13_written <= 1'b1;
      end else if (i_r13_clr) begin
        r_r13_written <= 1'b0;
      end
    end
  end

  assign o_rdata       = r_regs[i_raddr];
  assign o_r13_written = r_r13_written;

endmodule
`default_nettype wire

// File: rtl/ym_recorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ym_recorder : dumps a 16-byte YM2149 register snapshot per frame to RAM     |
// | Define YMREC_MASK_EN to mask unimplemented register bits when storing.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ym_recorder
  import ym_pkg::*;
#(
  parameter int RAM_WIDTH  = 17,
  parameter int MAX_FRAMES = 2 ** (RAM_WIDTH - 4)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vblank,
  input  logic [1:0]           addr,
  input  logic [7:0]           data_in,
  input  logic                 write,
  input  logic [3:0]           snd_addr,
  input  logic [7:0]           snd_data,
  input  logic                 snd_wr,
  output logic [RAM_WIDTH-1:0] ram_addr,
  output logic [7:0]           ram_data,
  output logic                 ram_we,
  output logic [RAM_WIDTH-5:0] frame_count,
  output logic                 recording,
  output logic                 full
);

  localparam int             c_fcw        = RAM_WIDTH - 4;
  // One bit wider than frame_count so a full-capacity count is representable.
  localparam logic [c_fcw:0] c_max_frames = (c_fcw + 1)'(MAX_FRAMES);

  ym_state_t            r_state;
  logic [7:0]           r_cmd;
  logic [RAM_WIDTH-1:0] r_base;
  logic [RAM_WIDTH-1:0] r_base_lat;
  logic [c_fcw-1:0]     r_frame_count;
  logic [3:0]           r_idx;
  logic                 r_stop_pend;
  logic                 r_vb_d;
  logic                 r_ram_we;
  logic [RAM_WIDTH-1:0] r_ram_addr;
  logic [7:0]           r_ram_data;
  logic                 r_recording;
  logic                 r_full;

  logic                 w_start;
  logic                 w_stop;
  logic                 w_vb_rise;
  logic                 w_r13_clr;
  logic                 w_r13_written;
  logic [7:0]           w_shadow_rd;
  logic [7:0]           w_dump_byte;
  logic [RAM_WIDTH-1:0] w_dump_addr;
  logic [c_fcw:0]       w_fc_inc;
  logic [4:0]           w_byte_sh;
  logic [23:0]          w_base_ext;
  logic [RAM_WIDTH-1:0] w_base_upd;

  // A pending command is only acted on in a cycle with no control write.
  assign w_start   = !write && (r_cmd == CMD_START);
  assign w_stop    = !write && (r_cmd == CMD_STOP);
  assign w_vb_rise = vblank && !r_vb_d;
  assign w_r13_clr = w_start || ((r_state == ST_DUMP) && (r_idx == 4'd13));

  ym_shadow_regs u_shadow (
    .clk           (clk),
    .reset         (reset),
    .i_wr          (snd_wr),
    .i_waddr       (snd_addr),
    .i_wdata       (snd_data),
    .i_raddr       (r_idx),
    .o_rdata       (w_shadow_rd),
    .i_r13_clr     (w_r13_clr),
    .o_r13_written (w_r13_written)
  );

  // Base registers 1..3 form a big-endian 24-bit address; only RAM_WIDTH bits are kept.
  always_comb begin
    w_byte_sh = 5'd0;
    case (addr)
      2'd1:    w_byte_sh = 5'd16;
      2'd2:    w_byte_sh = 5'd8;
      default: w_byte_sh = 5'd0;
    endcase
  end

  assign w_base_ext = 24'(r_base);
  assign w_base_upd = RAM_WIDTH'((w_base_ext & ~(24'hFF << w_byte_sh)) |
                                 (24'(data_in) << w_byte_sh));

  assign w_dump_addr = r_base_lat + {r_frame_count, 4'b0000} + RAM_WIDTH'(r_idx);
  assign w_fc_inc    = {1'b0, r_frame_count} + (c_fcw + 1)'(1);

  always_comb begin
    w_dump_byte = w_shadow_rd;
`ifdef YMREC_MASK_EN
    w_dump_byte = w_shadow_rd & reg_mask(r_idx);
`endif
    if ((r_idx == 4'd13) && !w_r13_written) begin
      w_dump_byte = R13_NOWRITE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cmd         <= '0;
      r_base        <= '0;
      r_base_lat    <= '0;
      r_frame_count <= '0;
      r_idx         <= '0;
      r_stop_pend   <= 1'b0;
      r_vb_d        <= 1'b0;
      r_ram_we      <= 1'b0;
      r_ram_addr    <= '0;
      r_ram_data    <= '0;
      r_recording   <= 1'b0;
      r_full        <= 1'b0;
    end else begin
      r_vb_d   <= vblank;
      r_ram_we <= 1'b0;

      if (write) begin
        if (addr == 2'd0) begin
          r_cmd <= data_in;
        end else begin
          r_base <= w_base_upd;
        end
      end else begin
        r_cmd <= '0;
      end

      if (w_start) begin
        r_base_lat    <= r_base;
        r_frame_count <= '0;
        r_idx         <= '0;
        r_stop_pend   <= 1'b0;
        r_state       <= ST_WAITFRAME;
        r_recording   <= 1'b1;
        r_full        <= 1'b0;
      end else begin
        case (r_state)
          ST_WAITFRAME: begin
            if (w_stop) begin
              r_state     <= ST_IDLE;
              r_recording <= 1'b0;
            end else if (w_vb_rise) begin
              r_state <= ST_DUMP;
              r_idx   <= '0;
            end
          end
          ST_DUMP: begin
            r_ram_we   <= 1'b1;
            r_ram_addr <= w_dump_addr;
            r_ram_data <= w_dump_byte;
            r_idx      <= r_idx + 4'd1;
            if (w_stop) begin
              r_stop_pend <= 1'b1;
            end
            if (r_idx == 4'd15) begin
              r_frame_count <= w_fc_inc[c_fcw-1:0];
              r_stop_pend   <= 1'b0;
              if (w_fc_inc == c_max_frames) begin
                r_state     <= ST_FULL;
                r_recording <= 1'b0;
                r_full      <= 1'b1;
              end else if (r_stop_pend || w_stop) begin
                r_state     <= ST_IDLE;
                r_recording <= 1'b0;
              end else begin
                r_state <= ST_WAITFRAME;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_data    = r_ram_data;
  assign frame_count = r_frame_count;
  assign recording   = r_recording;
  assign full        = r_full;

endmodule
`default_nettype wire

// File: tb/tb_ym_recorder.sv
`default_nettype none
// tb_ym_recorder: directed frame sequence with random register contents,
// checked against a frame-level behavioural model of the recorder.
module tb_ym_recorder;

  localparam int RW = 14;
  localparam int MF = 3;
  localparam int FW = RW - 4;

  logic          clk = 1'b0;
  logic          reset, vblank, write, snd_wr;
  logic [1:0]    addr;
  logic [7:0]    data_in, snd_data;
  logic [3:0]    snd_addr;
  logic [RW-1:0] ram_addr;
  logic [7:0]    ram_data;
  logic          ram_we, recording, full;
  logic [FW-1:0] frame_count;

  always #5 clk = ~clk;

  ym_recorder #(.RAM_WIDTH(RW), .MAX_FRAMES(MF)) dut (
    .clk(clk), .reset(reset), .vblank(vblank),
    .addr(addr), .data_in(data_in), .write(write),
    .snd_addr(snd_addr), .snd_data(snd_data), .snd_wr(snd_wr),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .frame_count(frame_count), .recording(recording), .full(full)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_writes = 0;
  int log_addr[$];
  int log_data[$];

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      log_addr.push_back(int'(ram_addr));
      log_data.push_back(int'(ram_data));
      n_writes++;
    end
  end

  // Behavioural model state
  int m_sh[16];
  bit m_r13w, m_rec, m_full;
  int m_base, m_fc, m_ctrl_base, m_cmd;

`ifdef YMREC_MASK_EN
  int mask_tab[16] = '{255, 15, 255, 15, 255, 15, 31, 255, 31, 31, 31, 255, 255, 15, 0, 0};
`endif

  function automatic int stored(input int r);
    if (r == 13 && !m_r13w) return 255;
`ifdef YMREC_MASK_EN
    return m_sh[r] & mask_tab[r];
`else
    return m_sh[r];
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_sh[i] = 0;
    m_r13w = 0; m_rec = 0; m_full = 0;
    m_base = 0; m_fc = 0; m_ctrl_base = 0; m_cmd = 0;
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_fc"},   frame_count, m_fc);
    chk({tag, "_rec"},  recording, m_rec);
    chk({tag, "_full"}, full, m_full);
  endtask

  task automatic snoop(input int r, input int v);
    snd_wr = 1'b1; snd_addr = r[3:0]; snd_data = v[7:0];
    tick();
    snd_wr = 1'b0;
    m_sh[r] = v & 255;
    if (r == 13) m_r13w = 1;
  endtask

  task automatic wr(input int a, input int d);
    int sh;
    write = 1'b1; addr = a[1:0]; data_in = d[7:0];
    tick();
    if (a == 0) begin
      m_cmd = d & 255;
    end else begin
      sh = 8 * (3 - a);
      m_ctrl_base = (m_ctrl_base & ~(255 << sh)) | ((d & 255) << sh);
    end
  endtask

  task automatic wr_end();
    write = 1'b0;
    tick();
    if (m_cmd == 1) begin
      m_base = m_ctrl_base & ((1 << RW) - 1);
      m_fc = 0; m_r13w = 0; m_rec = 1; m_full = 0;
    end else if (m_cmd == 2) begin
      m_rec = 0;
    end
    m_cmd = 0;
  endtask

  // One vblank pulse plus the following dump window. stop_at / snoop_at / reset_at
  // name the dump index at which that event lands; -1 disables it.
  task automatic frame(input string tag, input int stop_at, input int snoop_at,
                       input int sg, input int sv, input int reset_at);
    int exp_a[16];
    int exp_d[16];
    int n_exp;
    bit active;
    active = m_rec;
    n_exp = 0;
    if (active) begin
      n_exp = (reset_at >= 0) ? reset_at : 16;
      for (int r = 0; r < 16; r++) begin
        exp_a[r] = (m_base + m_fc * 16 + r) & ((1 << RW) - 1);
        exp_d[r] = stored(r);
        if (r == 13) m_r13w = 0;
        if (r == snoop_at) begin
          m_sh[sg] = sv & 255;
          if (sg == 13) m_r13w = 1;
        end
      end
    end
    log_addr.delete();
    log_data.delete();
    for (int k = 1; k <= 22; k++) begin
      vblank = (k == 1);
      if (stop_at >= 0 && k == stop_at + 1) begin
        write = 1'b1; addr = 2'd0; data_in = 8'd2;
      end else begin
        write = 1'b0;
      end
      if (snoop_at >= 0 && k == snoop_at + 2) begin
        snd_wr = 1'b1; snd_addr = sg[3:0]; snd_data = sv[7:0];
      end else begin
        snd_wr = 1'b0;
      end
      if (reset_at >= 0 && k == reset_at + 2) reset = 1'b1;
      tick();
      if (reset) break;
    end
    vblank = 1'b0; write = 1'b0; snd_wr = 1'b0;
    chk({tag, "_nwr"}, log_addr.size(), n_exp);
    for (int i = 0; i < n_exp && i < log_addr.size(); i++) begin
      chk($sformatf("%s_a%0d", tag, i), log_addr[i], exp_a[i]);
      chk($sformatf("%s_d%0d", tag, i), log_data[i], exp_d[i]);
    end
    if (reset_at >= 0) begin
      model_reset();
      chk({tag, "_rst_we"},   ram_we, 0);
      chk({tag, "_rst_addr"}, ram_addr, 0);
      chk({tag, "_rst_data"}, ram_data, 0);
      check_status({tag, "_rst"});
      reset = 1'b0;
      tick();
    end else begin
      if (active) begin
        m_fc++;
        if (m_fc == MF) begin
          m_full = 1; m_rec = 0;
        end else if (stop_at >= 0) begin
          m_rec = 0;
        end
      end
      chk({tag, "_we_low"}, ram_we, 0);
      check_status(tag);
    end
  endtask

  initial begin
    int w0;
    reset = 1'b1; vblank = 1'b0; write = 1'b0; addr = '0; data_in = '0;
    snd_wr = 1'b0; snd_addr = '0; snd_data = '0;
    model_reset();
    repeat (3) tick();
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);
    check_status("rst");
    reset = 1'b0;
    tick();

    // Random shadow contents, then the directed bytes.
    for (int r = 0; r < 16; r++) if (r != 13) snoop(r, $urandom_range(0, 255));
    snoop(0, 'h34);
    snoop(7, 'h38);
    snoop(1, 'hFF);
    wr(1, 'h00); wr(2, 'h10); wr(3, 'h00); wr(0, 1); wr_end();
    check_status("start0");
    w0 = n_writes;

    frame("f0", -1, -1, 0, 0, -1);
    chk("f0_addr0", log_addr[0], 'h1000);
    chk("f0_b0", log_data[0], 'h34);
    chk("f0_b7", log_data[7], 'h38);
    chk("f0_b13", log_data[13], 'hFF);
`ifdef YMREC_MASK_EN
    chk("f0_b1_mask", log_data[1], 'h0F);
`else
    chk("f0_b1_raw", log_data[1], 'hFF);
`endif

    snoop(13, 'h0A);
    snoop($urandom_range(0, 12), $urandom_range(0, 255));
    frame("f1", -1, -1, 0, 0, -1);
    chk("f1_b13", log_data[13], 'h0A);
    frame("f2", -1, -1, 0, 0, -1);
    chk("f2_b13", log_data[13], 'hFF);
    frame("f3_ignored", -1, -1, 0, 0, -1);
    chk("full_total_writes", n_writes - w0, 48);

    // Start from FULL; base bytes written after the start command must still be used.
    wr(0, 1); wr(1, $urandom_range(0, 255)); wr(2, 'h3F); wr(3, 'hF8); wr_end();
    check_status("start1");
    frame("g0", -1, 3, 3, $urandom_range(0, 255), -1);
    frame("g1", -1, 13, 13, 'h5A, -1);
    frame("g2", -1, -1, 0, 0, -1);

    // Stop while waiting for a frame.
    wr(0, 1); wr_end();
    wr(0, 2); wr_end();
    check_status("stop_wait");
    frame("h_idle", -1, -1, 0, 0, -1);

    // Stop in the middle of a dump.
    wr(0, 1); wr_end();
    snoop($urandom_range(0, 15), $urandom_range(0, 255));
    frame("s0", 5, -1, 0, 0, -1);
    frame("s_idle", -1, -1, 0, 0, -1);

    // Reset in the middle of a dump, then record once more from reset state.
    wr(2, $urandom_range(0, 63)); wr(0, 1); wr_end();
    frame("r0", -1, -1, 0, 0, 8);
    wr(0, 1); wr_end();
    frame("p0", -1, -1, 0, 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ym_recorder.md
YM_RECORDER -- requirements
Module: ym_recorder

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 17, meaning capture-RAM address width.
REQ-002 SHALL have parameter MAX_FRAMES, default 2**(RAM_WIDTH-4), meaning frame capacity before FULL.
REQ-003 SHALL have port clk, input, 1, system clock; reset, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port vblank, input, 1, frame tick; the rising edge marks the end of a frame.
REQ-005 SHALL have ports addr input 2, data_in input 8, write input 1: control register write port.
REQ-006 SHALL have ports snd_addr input 4, snd_data input 8, snd_wr input 1: snooped YM2149 register writes.
REQ-007 SHALL have ports ram_addr output RAM_WIDTH, ram_data output 8, ram_we output 1: capture RAM write port.
REQ-008 SHALL have ports frame_count output RAM_WIDTH-4, recording output 1, full output 1.

Function
REQ-009 Control regs: reg0 = command (1 = start, 2 = stop, other values ignored, self-clears to 0 after being acted on); reg1..3 = base address, big-endian, truncated to RAM_WIDTH.
REQ-010 A shadow file of 16 x 8-bit registers SHALL update on every cycle where snd_wr=1, in every state.
REQ-011 States: IDLE, WAITFRAME, DUMP, FULL; IDLE after reset.
REQ-012 Start (any state): latch base, frame_count=0, clear r13_written, go to WAITFRAME on the next cycle; a start issued during DUMP aborts the dump.
REQ-013 WAITFRAME: on a vblank rising edge (vblank=1, previous=0), go to DUMP with index r=0.
REQ-014 DUMP: one byte per cycle for r=0..15; ram_we=1, ram_addr=base+{frame_count,4'b0}+r (mod 2**RAM_WIDTH), ram_data=stored byte.
REQ-015 Stored byte = shadow[r], except for r=13: 8'hFF when r13_written=0.
REQ-016 r13_written SHALL be set by a snooped write to reg 13 and cleared when r=13 is dumped. If the set and the clear fall on the same cycle, the set wins.
REQ-017 If a snooped write hits reg r in the cycle r is dumped, the dumped value SHALL be the pre-write value.
REQ-018 After r=15: frame_count += 1; if the new value == MAX_FRAMES go to FULL, else WAITFRAME; ram_we=0 next cycle.
REQ-019 Stop in WAITFRAME SHALL go to IDLE immediately; stop in DUMP SHALL complete the frame (counted) and then go to IDLE.
REQ-020 recording=1 in WAITFRAME/DUMP; full=1 only in FULL; FULL is left only by start or reset.
REQ-021 vblank edges in IDLE/FULL/DUMP SHALL be ignored (no queued frame).
REQ-022 A control write and a command action in the same cycle: the write wins; the command is evaluated on the next non-write cycle.

Reset
REQ-023 On reset: state IDLE, ctrl regs 0, shadow 0, r13_written 0, frame_count 0, ram_we 0, ram_addr 0, ram_data 0, recording 0, full 0.
REQ-024 Reset mid-DUMP SHALL drop ram_we the following cycle; the partial frame is not counted.

Configuration
REQ-025 Macro YMREC_MASK_EN defined: stored bytes ANDed with per-register masks R0-R15 = FF,0F,FF,0F,FF,0F,1F,FF,1F,1F,1F,FF,FF,0F,00,00 (the 8'hFF R13 marker is exempt).
REQ-026 YMREC_MASK_EN undefined: raw shadow bytes stored.

Structure
REQ-027 State encoding, command codes (CMD_START=1, CMD_STOP=2), register mask table and R13_NOWRITE=8'hFF SHALL live in shared package ym_pkg, shared with the player.
REQ-028 The shadow file plus r13_written SHALL be a sub-module ym_shadow_regs (write port, async read port, r13 flag).

Verification
REQ-029 Base=0x001000, start, write R0=0x34, R7=0x38, one vblank -> 16 writes at 0x1000..0x100F, 0x1000=0x34, 0x1007=0x38, 0x100D=0xFF, frame_count=1.
REQ-030 Write R13=0x0A in frame 0, none in frame 1 -> byte 13 of frame 0 = 0x0A, byte 13 of frame 1 = 0xFF.
REQ-031 MAX_FRAMES=2, three vblanks -> exactly 32 writes, full=1, recording=0, third vblank ignored.
REQ-032 Stop asserted at DUMP r=5 -> r=6..15 still written, frame_count incremented, then IDLE.
REQ-033 Reset at DUMP r=8 -> ram_we=0 next cycle, all outputs at reset values.
REQ-034 With YMREC_MASK_EN, R1=0xFF dumped -> stored 0x0F; without the macro -> 0xFF.
